traffic_sched: RTL and testbench
================================

TRAFFIC_SCHED -- requirements
Module: traffic_sched

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, max consecutive packets granted to one channel while the other channel is waiting.
REQ-002 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports ch0_count, ch1_count  in  64  packet count per channel, sampled only on that channel's start pulse.
REQ-005 SHALL have ports ch0_start, ch1_start  in  1  one-cycle start pulses from the AXI register block.
REQ-006 SHALL have port pkt_req  out  1  request to shared 512-bit packet generator.
REQ-007 SHALL have port pkt_chan  out  1  channel owning the current request (0/1).
REQ-008 SHALL have port pkt_ack  in  1  generator accepted the request; counts only when pkt_req=1.
REQ-009 SHALL have ports ch0_busy, ch1_busy  out  1  channel has packets remaining.
REQ-010 SHALL have ports ch0_done, ch1_done  out  1  one-cycle pulse when the channel's last packet is acked.
REQ-011 SHALL have ports ch0_sent, ch1_sent  out  64  packets acked since that channel's last accepted start.

Function
REQ-012 SHALL, on chX_start with chX_busy=0 and chX_count!=0, load remaining_X=chX_count, clear chX_sent, set chX_busy next cycle.
REQ-013 SHALL ignore chX_start while chX_busy=1 (no reload, no counter change).
REQ-014 SHALL, on chX_start with chX_count=0 and chX_busy=0, clear chX_sent, pulse chX_done next cycle, leave busy low.
REQ-015 SHALL implement states IDLE and REQ; IDLE->REQ when any busy=1; REQ->IDLE when the ack retires the last remaining packet of all channels.
REQ-016 SHALL assert pkt_req exactly while in REQ; first pkt_req is one cycle after busy rises (two cycles after start).
REQ-017 SHALL hold pkt_req and pkt_chan stable from assertion until the pkt_ack cycle.
REQ-018 SHALL, per ack: decrement remaining of pkt_chan, increment its sent, increment burst counter.
REQ-019 SHALL choose next owner at each ack: switch if burst counter reaches BURST_LEN and the other channel is busy, or if current channel just emptied; else keep; burst counter clears on switch.
REQ-020 SHALL use busy flags registered before the ack cycle for REQ-019; a start in the ack cycle joins the following arbitration.
REQ-021 SHALL, leaving IDLE with both busy, grant channel 0 first.
REQ-022 SHALL keep pkt_req high with no idle cycle between consecutive requests when work remains.
REQ-023 SHALL drop chX_busy and pulse chX_done in the cycle after the final ack of channel X.
REQ-024 SHALL support counts up to 2^64-1; remaining never wraps below 0; sent saturates at 2^64-1.

Reset
REQ-025 SHALL, on reset=1, set state=IDLE, pkt_req=0, pkt_chan=0, busy=0, done=0, sent=0, remaining=0, burst counter=0, next cycle.
REQ-026 SHALL let reset override in-flight requests; an ack coincident with reset is discarded.

Structure
REQ-027 SHALL place state encoding and BURST_LEN default in package traffic_sched_pkg.
REQ-028 SHALL instantiate sub-module traffic_chan_ctr twice (load, decrement, sent, busy, done per channel).

Verification
REQ-029 SHALL test: ch0_count=3, ch0_start, ack every cycle -> pkt_req at start+2, three acks chan 0, ch0_done once, ch0_sent=3.
REQ-030 SHALL test: both counts=6, simultaneous starts, BURST_LEN=4 -> grant order 0,0,0,0,1,1,1,1,0,0,1,1.
REQ-031 SHALL test: ch1_count=0, ch1_start -> ch1_done pulse, ch1_busy never 1, pkt_req stays 0.
REQ-032 SHALL test: ch0_start during ch0 busy with new count=100 -> ignored, original count completes.
REQ-033 SHALL test: pkt_ack held low 10 cycles -> pkt_req/pkt_chan stable throughout, no counter change.
REQ-034 SHALL test: reset asserted mid-burst with ack high -> all outputs reset values next cycle, sent=0.

Source files
------------

// File: rtl/traffic_sched_pkg.sv
// Shared definitions for the two-channel packet scheduler: state encoding,
// counter width, default burst length and a saturating increment helper.
package traffic_sched_pkg;

  localparam int unsigned TS_CNT_W             = 64;
  localparam int unsigned TS_BURST_LEN_DEFAULT = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } sched_state_e;

  function automatic logic [TS_CNT_W-1:0] sat_inc(input logic [TS_CNT_W-1:0] v);
    if (v == {TS_CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 64'd1;
    end
  endfunction

endpackage

// File: rtl/traffic_chan_ctr.sv
// Per-channel bookkeeping: loads the packet count on an accepted start,
// retires one packet per ack and reports busy/done/sent.
module traffic_chan_ctr
  import traffic_sched_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [TS_CNT_W-1:0] count,
  input  logic                dec,
  output logic                busy,
  output logic                done,
  output logic                last,
  output logic [TS_CNT_W-1:0] sent
);

  logic [TS_CNT_W-1:0] remaining_r;

  // Load on idle start, retire one packet per ack, pulse done on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining_r <= {TS_CNT_W{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      sent        <= {TS_CNT_W{1'b0}};
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        sent <= {TS_CNT_W{1'b0}};
        if (count != 64'd0) begin
          remaining_r <= count;
          busy        <= 1'b1;
        end else begin
          done <= 1'b1;
        end
      end else if (dec && busy) begin
        sent <= sat_inc(sent);
        if (remaining_r != 64'd0) begin
          remaining_r <= remaining_r - 64'd1;
        end
        if (remaining_r <= 64'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // The scheduler needs to know in the ack cycle whether this ack empties the channel.
  assign last = (remaining_r == 64'd1);

endmodule

// File: rtl/traffic_sched.sv
// Two-channel arbiter in front of a shared packet generator: round-robin
// with bounded bursts, channel 0 first when both start together.
module traffic_sched
  import traffic_sched_pkg::*;
#(
  parameter int unsigned BURST_LEN = TS_BURST_LEN_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [TS_CNT_W-1:0] ch0_count,
  input  logic [TS_CNT_W-1:0] ch1_count,
  input  logic                ch0_start,
  input  logic                ch1_start,
  output logic                pkt_req,
  output logic                pkt_chan,
  input  logic                pkt_ack,
  output logic                ch0_busy,
  output logic                ch1_busy,
  output logic                ch0_done,
  output logic                ch1_done,
  output logic [TS_CNT_W-1:0] ch0_sent,
  output logic [TS_CNT_W-1:0] ch1_sent
);

  localparam int unsigned    BW        = $clog2(BURST_LEN + 1) + 1;
  localparam logic [BW-1:0]  BURST_MAX = BURST_LEN[BW-1:0];

  sched_state_e  state_r, state_s;
  logic          chan_r, chan_s;
  logic [BW-1:0] burst_r, burst_s, burst_inc_s;
  logic          ack_s, dec0_s, dec1_s, last0_s, last1_s;
  logic          cur_last_s, oth_busy_s;

  assign ack_s  = (state_r == ST_REQ) && pkt_ack;
  assign dec0_s = ack_s && (chan_r == 1'b0);
  assign dec1_s = ack_s && (chan_r == 1'b1);

  traffic_chan_ctr u_ch0 (
    .clk   (clk),
    .reset (reset),
    .start (ch0_start),
    .count (ch0_count),
    .dec   (dec0_s),
    .busy  (ch0_busy),
    .done  (ch0_done),
    .last  (last0_s),
    .sent  (ch0_sent)
  );

  traffic_chan_ctr u_ch1 (
    .clk   (clk),
    .reset (reset),
    .start (ch1_start),
    .count (ch1_count),
    .dec   (dec1_s),
    .busy  (ch1_busy),
    .done  (ch1_done),
    .last  (last1_s),
    .sent  (ch1_sent)
  );

  // Next owner is decided only at an ack, from busy flags registered before it.
  always_comb begin
    state_s     = state_r;
    chan_s      = chan_r;
    burst_s     = burst_r;
    cur_last_s  = chan_r ? last1_s : last0_s;
    oth_busy_s  = chan_r ? ch0_busy : ch1_busy;
    if (burst_r >= BURST_MAX) begin
      burst_inc_s = burst_r;
    end else begin
      burst_inc_s = burst_r + {{(BW-1){1'b0}}, 1'b1};
    end
    case (state_r)
      ST_IDLE: begin
        if (ch0_busy || ch1_busy) begin
          state_s = ST_REQ;
          chan_s  = ch0_busy ? 1'b0 : 1'b1;
          burst_s = {BW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (pkt_ack) begin
          if (cur_last_s && !oth_busy_s) begin
            state_s = ST_IDLE;
            burst_s = {BW{1'b0}};
          end else if (cur_last_s || ((burst_inc_s >= BURST_MAX) && oth_busy_s)) begin
            chan_s  = ~chan_r;
            burst_s = {BW{1'b0}};
          end else begin
            burst_s = burst_inc_s;
          end
        end else begin
          state_s = ST_REQ;
        end
      end
      default: begin
        state_s = ST_IDLE;
        chan_s  = 1'b0;
        burst_s = {BW{1'b0}};
      end
    endcase
  end

  // Scheduler state register; reset wins over any ack in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      chan_r  <= 1'b0;
      burst_r <= {BW{1'b0}};
    end else begin
      state_r <= state_s;
      chan_r  <= chan_s;
      burst_r <= burst_s;
    end
  end

  assign pkt_req  = (state_r == ST_REQ);
  assign pkt_chan = chan_r;

endmodule

// File: tb/tb_traffic_sched.sv
// Scoreboard bench: expected grant order is computed from the channel counts
// and queued; a monitor pops and compares on every accepted request.
module tb_traffic_sched;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        reset, ch0_start, ch1_start, pkt_ack;
  logic        pkt_req, pkt_chan, ch0_busy, ch1_busy, ch0_done, ch1_done;
  logic [63:0] ch0_count, ch1_count, ch0_sent, ch1_sent;

  int   checks = 0;
  int   errors = 0;
  int   ack_pct = 100;
  int   done_cnt0 = 0;
  int   done_cnt1 = 0;
  logic exp_q[$];
  logic [63:0] exp_sent0 = 64'd0;
  logic [63:0] exp_sent1 = 64'd0;

  always #5 clk = ~clk;

  traffic_sched #(.BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset),
    .ch0_count(ch0_count), .ch1_count(ch1_count),
    .ch0_start(ch0_start), .ch1_start(ch1_start),
    .pkt_req(pkt_req), .pkt_chan(pkt_chan), .pkt_ack(pkt_ack),
    .ch0_busy(ch0_busy), .ch1_busy(ch1_busy),
    .ch0_done(ch0_done), .ch1_done(ch1_done),
    .ch0_sent(ch0_sent), .ch1_sent(ch1_sent)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference: grant sequence for channels started together, from counts alone.
  task automatic push_order(input int c0, input int c1);
    int rem[2];
    int owner;
    int run;
    rem[0] = c0;
    rem[1] = c1;
    owner  = (c0 > 0) ? 0 : 1;
    run    = 0;
    while (rem[0] + rem[1] > 0) begin
      exp_q.push_back(owner == 1);
      rem[owner]--;
      run++;
      if (rem[owner] == 0) begin
        owner = 1 - owner;
        run   = 0;
      end else if (run >= BL && rem[1 - owner] > 0) begin
        owner = 1 - owner;
        run   = 0;
      end
    end
  endtask

  task automatic start_ch(input int mask, input int c0, input int c1);
    ch0_count = 64'(c0);
    ch1_count = 64'(c1);
    ch0_start = (mask & 1) != 0;
    ch1_start = (mask & 2) != 0;
    tick();
    ch0_start = 1'b0;
    ch1_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ch0_busy || ch1_busy || pkt_req) && n < 2000) begin
      tick();
      n++;
    end
    check1({name, "_finished"}, n < 2000, 1'b1);
    tick();
    tick();
    check64({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_scn(input string name, input int mask, input int c0, input int c1);
    int e0, e1, d0, d1;
    e0 = ((mask & 1) != 0) ? c0 : 0;
    e1 = ((mask & 2) != 0) ? c1 : 0;
    if ((mask & 1) != 0) exp_sent0 = 64'(c0);
    if ((mask & 2) != 0) exp_sent1 = 64'(c1);
    d0 = done_cnt0;
    d1 = done_cnt1;
    push_order(e0, e1);
    start_ch(mask, c0, c1);
    wait_idle(name);
    check64({name, "_sent0"}, ch0_sent, exp_sent0);
    check64({name, "_sent1"}, ch1_sent, exp_sent1);
    check64({name, "_done0"}, 64'(done_cnt0 - d0), ((mask & 1) != 0) ? 64'd1 : 64'd0);
    check64({name, "_done1"}, 64'(done_cnt1 - d1), ((mask & 2) != 0) ? 64'd1 : 64'd0);
  endtask

  // Ack driver: random acceptance at the configured rate.
  initial begin
    pkt_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pkt_ack = ($urandom_range(99) < ack_pct);
    end
  end

  // Monitor: grant scoreboard, request stability while stalled, done counting.
  initial begin
    logic prev_stall;
    logic prev_chan;
    prev_stall = 1'b0;
    prev_chan  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check1("hold_req", pkt_req, 1'b1);
          check1("hold_chan", pkt_chan, prev_chan);
        end
        if (pkt_req && pkt_ack) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL grant_unexpected: got chan %0d expected no grant", pkt_chan);
          end else begin
            check1("grant_chan", pkt_chan, exp_q.pop_front());
          end
        end
        if (ch0_done) done_cnt0++;
        if (ch1_done) done_cnt1++;
        prev_stall = pkt_req && !pkt_ack;
        prev_chan  = pkt_chan;
      end
    end
  end

  initial begin
    int d0, d1, m, c0, c1;
    reset = 1'b1; ch0_start = 1'b0; ch1_start = 1'b0;
    ch0_count = 64'd0; ch1_count = 64'd0;
    repeat (3) tick();
    check1("rst_req", pkt_req, 1'b0);
    check1("rst_chan", pkt_chan, 1'b0);
    check1("rst_busy0", ch0_busy, 1'b0);
    check1("rst_busy1", ch1_busy, 1'b0);
    check64("rst_sent0", ch0_sent, 64'd0);
    check64("rst_sent1", ch1_sent, 64'd0);
    reset = 1'b0;
    tick();

    // Single channel, three packets, ack every cycle.
    ack_pct = 100;
    tick();
    d0 = done_cnt0;
    push_order(3, 0);
    exp_sent0 = 64'd3;
    start_ch(1, 3, 0);
    check1("r029_req_start+1", pkt_req, 1'b0);
    check1("r029_busy_start+1", ch0_busy, 1'b1);
    tick();
    check1("r029_req_start+2", pkt_req, 1'b1);
    check1("r029_chan_start+2", pkt_chan, 1'b0);
    wait_idle("r029");
    check64("r029_sent0", ch0_sent, 64'd3);
    check64("r029_done0", 64'(done_cnt0 - d0), 64'd1);

    // Both channels, six packets each: bursts of four then alternation.
    run_scn("r030", 3, 6, 6);

    // Zero count start: done only, never busy, no request.
    d1 = done_cnt1;
    exp_sent1 = 64'd0;
    start_ch(2, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check1("r031_busy1", ch1_busy, 1'b0);
      check1("r031_req", pkt_req, 1'b0);
      tick();
    end
    check64("r031_done1", 64'(done_cnt1 - d1), 64'd1);
    check64("r031_sent1", ch1_sent, 64'd0);

    // Stall for ten cycles with a restart attempt while busy.
    ack_pct = 0;
    tick();
    tick();
    d0 = done_cnt0;
    push_order(5, 0);
    exp_sent0 = 64'd5;
    start_ch(1, 5, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      check1("r033_req", pkt_req, 1'b1);
      check1("r033_chan", pkt_chan, 1'b0);
      check64("r033_sent0", ch0_sent, 64'd0);
      if (i == 3) begin
        ch0_count = 64'd100;
        ch0_start = 1'b1;
      end else begin
        ch0_start = 1'b0;
      end
      tick();
    end
    ch0_start = 1'b0;
    ack_pct = 100;
    wait_idle("r032");
    check64("r032_sent0", ch0_sent, 64'd5);
    check64("r032_done0", 64'(done_cnt0 - d0), 64'd1);

    // Randomized count/start/ack-rate scenarios.
    for (int k = 0; k < 10; k++) begin
      m  = $urandom_range(1, 3);
      c0 = $urandom_range(0, 9);
      c1 = $urandom_range(0, 9);
      ack_pct = $urandom_range(30, 100);
      tick();
      run_scn("rand", m, c0, c1);
    end

    // Reset in the middle of a burst with ack held high.
    ack_pct = 100;
    tick();
    tick();
    push_order(8, 8);
    start_ch(3, 8, 8);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check1("r034_req", pkt_req, 1'b0);
    check1("r034_chan", pkt_chan, 1'b0);
    check1("r034_busy0", ch0_busy, 1'b0);
    check1("r034_busy1", ch1_busy, 1'b0);
    check1("r034_done0", ch0_done, 1'b0);
    check1("r034_done1", ch1_done, 1'b0);
    check64("r034_sent0", ch0_sent, 64'd0);
    check64("r034_sent1", ch1_sent, 64'd0);
    exp_q.delete();
    reset = 1'b0;
    repeat (3) tick();
    check1("r034_req_after", pkt_req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
